// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - address/control sequencer for an in-place 32-point radix-2 DIT FFT
// Walks 5 stages x 16 butterflies: read pair, wait BF_LAT-1, write pair back to the same addresses.
module fft_seq_ctrl #(
  parameter int BF_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] ram_addra,
  output logic [4:0] ram_addrb,
  output logic       ram_ena,
  output logic       ram_enb,
  output logic       bf_load,
  output logic [3:0] tw_idx,
  output logic [2:0] stage
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_e;

  localparam logic [2:0] WAIT_INIT = (BF_LAT > 1) ? 3'(BF_LAT - 2) : 3'd0;

  state_e     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [3:0] k_q, k_d;
  logic [2:0] wait_q, wait_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= 3'd0;
      k_q     <= 4'd0;
      wait_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          stage_d = 3'd0;
          k_d     = 4'd0;
        end
      end
      S_RD: begin
        if (BF_LAT == 1) begin
          state_d = S_WR;
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 3'd0) state_d = S_WR;
        else                wait_d  = wait_q - 3'd1;
      end
      S_WR: begin
        if (k_q != 4'd15) begin
          k_d     = k_q + 4'd1;
          state_d = S_RD;
        end else if (stage_q != 3'd4) begin
          stage_d = stage_q + 3'd1;
          k_d     = 4'd0;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Butterfly k of stage s pairs a and a+2^s inside groups of 2^(s+1) words.
  logic [4:0] k_ext, span, pos, addr_a, addr_b;
  logic [3:0] tw;
  logic       active;

  always_comb begin
    k_ext  = {1'b0, k_q};
    span   = 5'd1 << stage_q;
    pos    = k_ext & (span - 5'd1);
    addr_a = ((k_ext >> stage_q) << (stage_q + 3'd1)) | pos;
    addr_b = addr_a + span;
    tw     = pos[3:0] << (3'd4 - stage_q);
  end

  assign active    = (state_q != S_IDLE);
  assign busy      = active;
  assign done      = done_q;
  assign ram_addra = active ? addr_a : 5'd0;
  assign ram_addrb = active ? addr_b : 5'd0;
  assign tw_idx    = active ? tw : 4'd0;
  assign bf_load   = (state_q == S_RD);
  assign ram_ena   = (state_q == S_WR);
  assign ram_enb   = (state_q == S_WR);
  assign stage     = stage_q;

endmodule
